// File: rtl/conv_stream_bridge.sv
// conv_stream_bridge
//   Host-side bridge for the convolution processor. Loads an operand byte
//   stream into the X memory (sizeX bytes) and then the Y memory (sizeY bytes),
//   pulses start_o, waits for done_i, then reads sizeX+sizeY-1 results from the
//   Z memory and emits them as a valid/ready stream with m_last_o on the final one.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   go_i, sizeX_i, sizeY_i    job request and operand lengths (sampled in IDLE)
//   s_data_i/s_valid_i/s_ready_o   operand input stream (all X, then all Y)
//   memX_*_o, memY_*_o        X/Y memory write ports
//   start_o, done_i           processor handshake
//   memZ_addr_o/memZ_re_o/memZ_data_i   Z memory read port (1-cycle latency)
//   m_data_o/m_valid_o/m_ready_i/m_last_o   result output stream
//   busy_o, err_o             status: not IDLE / go rejected for a zero size
//   dbg_state_o               current FSM state
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid and ready are both 1. Once m_valid_o is raised, m_data_o and m_last_o
// are held unchanged until that transfer; m_valid_o never depends on m_ready_i.
module conv_stream_bridge #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int ZDATA_WIDTH = 16,
  parameter int ZADDR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go_i,
  input  logic [ADDR_WIDTH-1:0]  sizeX_i,
  input  logic [ADDR_WIDTH-1:0]  sizeY_i,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [ADDR_WIDTH-1:0]  memX_addr_o,
  output logic [DATA_WIDTH-1:0]  memX_data_o,
  output logic                   memX_we_o,
  output logic [ADDR_WIDTH-1:0]  memY_addr_o,
  output logic [DATA_WIDTH-1:0]  memY_data_o,
  output logic                   memY_we_o,
  output logic                   start_o,
  input  logic                   done_i,
  output logic [ZADDR_WIDTH-1:0] memZ_addr_o,
  output logic                   memZ_re_o,
  input  logic [ZDATA_WIDTH-1:0] memZ_data_i,
  output logic [ZDATA_WIDTH-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [2:0]             dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_X = 3'd1;
  localparam logic [2:0] S_LOAD_Y = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RD_REQ = 3'd5;
  localparam logic [2:0] S_RD_CAP = 3'd6;
  localparam logic [2:0] S_RD_OUT = 3'd7;

  logic [2:0]             state;
  logic [ADDR_WIDTH-1:0]  size_x;
  logic [ADDR_WIDTH-1:0]  size_y;
  logic [ADDR_WIDTH-1:0]  cnt;
  logic [ZADDR_WIDTH-1:0] zcnt;
  logic [ZADDR_WIDTH-1:0] last_idx;
  logic [ZADDR_WIDTH-1:0] last_idx_next;
  logic                   s_fire;

  // Index of the final result (sizeX+sizeY-2); both sizes are nonzero when used.
  assign last_idx_next = ZADDR_WIDTH'(sizeX_i) + ZADDR_WIDTH'(sizeY_i) - ZADDR_WIDTH'(2);

  assign s_ready_o = (state == S_LOAD_X) || (state == S_LOAD_Y);
  assign s_fire    = s_valid_i && s_ready_o;

  // Memory ports carry the counter and data only in their own phase, 0 otherwise.
  assign memX_we_o   = s_fire && (state == S_LOAD_X);
  assign memX_addr_o = (state == S_LOAD_X) ? cnt : '0;
  assign memX_data_o = (state == S_LOAD_X) ? s_data_i : '0;
  assign memY_we_o   = s_fire && (state == S_LOAD_Y);
  assign memY_addr_o = (state == S_LOAD_Y) ? cnt : '0;
  assign memY_data_o = (state == S_LOAD_Y) ? s_data_i : '0;

  assign start_o     = (state == S_START);
  assign memZ_re_o   = (state == S_RD_REQ);
  assign memZ_addr_o = (state == S_RD_REQ) ? zcnt : '0;
  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      size_x    <= '0;
      size_y    <= '0;
      cnt       <= '0;
      zcnt      <= '0;
      last_idx  <= '0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_i) begin
            if ((sizeX_i != '0) && (sizeY_i != '0)) begin
              size_x   <= sizeX_i;
              size_y   <= sizeY_i;
              last_idx <= last_idx_next;
              cnt      <= '0;
              zcnt     <= '0;
              state    <= S_LOAD_X;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_LOAD_X: begin
          if (s_fire) begin
            if (cnt == size_x - ADDR_WIDTH'(1)) begin
              cnt   <= '0;
              state <= S_LOAD_Y;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        S_LOAD_Y: begin
          if (s_fire) begin
            if (cnt == size_y - ADDR_WIDTH'(1)) begin
              cnt   <= '0;
              state <= S_START;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (done_i) begin
            zcnt  <= '0;
            state <= S_RD_REQ;
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          // Z read data arrives this cycle, one cycle after the request.
          m_data_o  <= memZ_data_i;
          m_valid_o <= 1'b1;
          m_last_o  <= (zcnt == last_idx);
          state     <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            if (m_last_o) begin
              state <= S_IDLE;
            end else begin
              zcnt  <= zcnt + ZADDR_WIDTH'(1);
              state <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
